polyvec_unpack_stream: RTL
==========================

# polyvec_unpack_stream

Streaming, parametrised unpacker that turns packed Kyber polynomial-vector bytes (12-bit coefficients, 8 per 96-bit beat) into 128-bit BRAM words of eight 16-bit lanes. It serves two modes. Encryption unpacks the public-key polyvec, with an FIPS 203 modulus check. Decryption unpacks the secret-key polyvec and splits each coefficient into two arithmetic shares mod q using PRNG data. It sits between the key-buffer reader and the polyvec BRAM write port. It replaces the wide-bus, fixed-K unpack path with a valid/ready stream that supports backpressure and any K.

## Interface
- KYBER_K, 2, polynomials per vector (2/3/4)
- KYBER_N, 256, coefficients per polynomial
- KYBER_Q, 3329, modulus
- LANES, 8, coefficients per beat
- COEF_BITS, 12, packed coefficient width
- LANE_BITS, 16, output lane width
- IN_W, LANES*COEF_BITS (96), input beat width
- OUT_W, LANES*LANE_BITS (128), output word width
- WORDS, KYBER_K*KYBER_N/LANES (64), words per vector
- ADDR_W, $clog2(WORDS) (6), address width

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a vector
- mode  in  1  0 = enc/pk, 1 = dec/sk; sampled at start
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid && in_ready
- in_data  in  IN_W  packed bytes, byte 0 at [7:0]
- PRNG_enable  out  1  PRNG_data consumed this cycle
- PRNG_data  in  IN_W  LANES 12-bit randoms, lane j at [12j+11:12j]
- out_valid  out  1  output word valid
- out_ready  in  1  downstream accepts
- out_addr  out  ADDR_W  word index
- out_data_s1  out  OUT_W  share 1 (or plain coefficients)
- out_data_s2  out  OUT_W  share 2 (zero in mode 0)
- busy  out  1  state != IDLE
- done  out  1  one-cycle completion pulse
- coeff_err  out  1  sticky: some coefficient was >= KYBER_Q

## Operation
- FSM states: IDLE, RUN, DRAIN, FIN.
  - IDLE→RUN on start. Clears in/out counters, out_addr, coeff_err; latches mode.
  - RUN→DRAIN on acceptance of beat WORDS-1.
  - DRAIN→FIN when out_valid=0, or when the final word handshakes.
  - FIN→IDLE unconditionally.
- start is ignored unless in IDLE.
- Lane decode: c_j = in_data[12j+11:12j] (little-endian 12-bit packing).
- Output lane j occupies [16j+15:16j], with the upper 4 bits zero.
- Mode 0: s1_j = c_j raw, s2_j = 0.
- Mode 1:
  - c' = c>=q ? c-q : c
  - r_j = PRNG_data lane j; r' = r>=q ? r-q : r
  - s2 = r'; s1 = c'-r' + (c'<r' ? q : 0)
  - Invariant: (s1+s2) mod q = c'.
- coeff_err sets in either mode when any accepted c_j >= KYBER_Q. It holds until the next start or rst.
- PRNG_enable = in_valid && in_ready && mode_q. It is combinational.
- out_addr increments on each out handshake. It never exceeds WORDS-1.

## Timing
- in_ready = (state==RUN) && (!out_valid || out_ready). This sustains 1 word/cycle.
- Latency: a beat accepted at edge t gives out_valid=1 with data after edge t.
- While out_valid && !out_ready: out_data_s1, out_data_s2 and out_addr are held stable.
- done pulses in FIN, one cycle after the last output handshake. busy falls in the same cycle.
- On rst, at the next edge:
  - state = IDLE
  - out_valid, out_addr, out_data_s1, out_data_s2, done, coeff_err = 0
  - counters = 0
- Reset mid-vector discards partial data. No done is issued.
- start and rst in the same cycle: rst wins.

## Configuration
- POLYVEC_UNPACK_MASK_EN defined: mode 1 masking as specified above.
- Macro undefined:
  - mode 1 gives s1 = c' (reduced) and s2 = 0.
  - PRNG_enable is tied 0 and PRNG_data is unused.
  - No share logic is synthesised.

## Structure
- Shared package holds KYBER_Q, the state enum (IDLE/RUN/DRAIN/FIN), and the lane decode/reduce functions.
- One sub-module, polyvec_lane_mask, handles a single coefficient: reduce, range flag and share split. It is instantiated LANES times.

## Test plan
- K=2, mode 0, beat bytes 0x23,0x61,0x45 repeated → lane0=0x0123, lane1=0x0456. 64 words at addr 0..63, then done one cycle after word 63; s2=0.
- out_ready low for 5 cycles mid-run → in_ready=0, out_data and out_addr frozen, no word lost or duplicated. Total of 64 handshakes.
- Mode 1 with c=0x001:
  - r=0xFFF → s2=0x2FE, s1=0xA04.
  - r=0x000 → s1=0x001, s2=0.
  - Random sweep checks (s1+s2) mod 3329 = c'.
- Mode 0 with a coefficient 0xD01 → coeff_err=1 and held to done. The next start clears it. In mode 1 the same input gives c'=0.
- rst asserted after 10 words → all outputs 0 next cycle. A new start restarts at out_addr 0. start pulsed while busy is ignored.
- KYBER_K=4 build → ADDR_W=7, 128 words, done after addr 127.

Source files
------------

// File: rtl/polyvec_unpack_stream_pkg.sv
// Shared constants, FSM state type and lane helpers for the polyvec unpacker.
package polyvec_unpack_stream_pkg;

   localparam int KYBER_N   = 256;
   localparam int KYBER_Q   = 3329;
   localparam int LANES     = 8;
   localparam int COEF_BITS = 12;
   localparam int LANE_BITS = 16;
   localparam int IN_W      = LANES * COEF_BITS;
   localparam int OUT_W     = LANES * LANE_BITS;

   localparam logic [COEF_BITS-1:0] Q12 = COEF_BITS'(KYBER_Q);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      FIN
   } state_e;

   function automatic logic [COEF_BITS-1:0] lane_decode(
      input logic [IN_W-1:0] d,
      input int unsigned     j
   );
      return d[j*COEF_BITS +: COEF_BITS];
   endfunction

   // Single conditional subtract suffices: 12-bit inputs are < 2q.
   function automatic logic [COEF_BITS-1:0] reduce_q(
      input logic [COEF_BITS-1:0] c
   );
      return (c >= Q12) ? c - Q12 : c;
   endfunction

endpackage

// File: rtl/polyvec_unpack_stream_if.sv
// Input beat / PRNG / output word bundle between key reader,
// unpacker and polyvec BRAM port.
interface polyvec_unpack_stream_if
   import polyvec_unpack_stream_pkg::*;
#(
   parameter int ADDR_W = 6
) ();

   logic              in_valid;
   logic              in_ready;
   logic [IN_W-1:0]   in_data;
   logic              PRNG_enable;
   logic [IN_W-1:0]   PRNG_data;
   logic              out_valid;
   logic              out_ready;
   logic [ADDR_W-1:0] out_addr;
   logic [OUT_W-1:0]  out_data_s1;
   logic [OUT_W-1:0]  out_data_s2;

   modport master (
      output in_valid, in_data, PRNG_data, out_ready,
      input  in_ready, PRNG_enable, out_valid, out_addr,
      input  out_data_s1, out_data_s2
   );

   modport slave (
      input  in_valid, in_data, PRNG_data, out_ready,
      output in_ready, PRNG_enable, out_valid, out_addr,
      output out_data_s1, out_data_s2
   );

endinterface

// File: rtl/polyvec_lane_mask.sv
// One coefficient lane: reduce mod q, range flag and optional share split.
// Share split only exists when POLYVEC_UNPACK_MASK_EN is defined.
module polyvec_lane_mask
   import polyvec_unpack_stream_pkg::*;
(
   input  logic                 dec_mode,
   input  logic [COEF_BITS-1:0] coef,
   input  logic [COEF_BITS-1:0] rnd,
   output logic [LANE_BITS-1:0] s1,
   output logic [LANE_BITS-1:0] s2,
   output logic                 err
);

   logic [COEF_BITS-1:0] c_red;

   assign c_red = reduce_q(coef);
   assign err   = (coef >= Q12);

`ifdef POLYVEC_UNPACK_MASK_EN
   logic [COEF_BITS-1:0] r_red;
   logic [COEF_BITS-1:0] diff;

   // Wraps mod 4096 when c' < r'; adding q lands back in [0,q).
   assign r_red = reduce_q(rnd);
   assign diff  = c_red - r_red + ((c_red < r_red) ? Q12 : '0);

   always_comb begin
      s1 = LANE_BITS'(coef);
      s2 = '0;
      if (dec_mode) begin
         s1 = LANE_BITS'(diff);
         s2 = LANE_BITS'(r_red);
      end
   end
`else
   logic unused_rnd;

   assign unused_rnd = ^rnd;

   always_comb begin
      s1 = dec_mode ? LANE_BITS'(c_red) : LANE_BITS'(coef);
      s2 = '0;
   end
`endif

endmodule

// File: rtl/polyvec_unpack_stream.sv
// Streaming Kyber polyvec unpacker: 96-bit packed beats to 128-bit lanes.
// Define POLYVEC_UNPACK_MASK_EN to split decryption coefficients into shares.
module polyvec_unpack_stream
   import polyvec_unpack_stream_pkg::*;
#(
   parameter  int KYBER_K = 2,
   localparam int WORDS   = KYBER_K * KYBER_N / LANES,
   localparam int ADDR_W  = $clog2(WORDS)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     mode,
   polyvec_unpack_stream_if.slave   bus,
   output logic                     busy,
   output logic                     done,
   output logic                     coeff_err
);

   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(WORDS - 1);

   state_e              state_q, state_d;
   logic                mode_q, mode_d;
   logic [ADDR_W-1:0]   in_cnt_q, in_cnt_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                out_valid_q, out_valid_d;
   logic [OUT_W-1:0]    s1_q, s1_d;
   logic [OUT_W-1:0]    s2_q, s2_d;
   logic                err_q, err_d;

   logic                in_ready;
   logic                in_fire;
   logic                out_fire;
   logic [LANES-1:0]    err_w;
   logic [OUT_W-1:0]    s1_w;
   logic [OUT_W-1:0]    s2_w;

   for (genvar j = 0; j < LANES; j++) begin : g_lane
      polyvec_lane_mask u_lane (
         .dec_mode (mode_q),
         .coef     (lane_decode(bus.in_data, j)),
         .rnd      (lane_decode(bus.PRNG_data, j)),
         .s1       (s1_w[j*LANE_BITS +: LANE_BITS]),
         .s2       (s2_w[j*LANE_BITS +: LANE_BITS]),
         .err      (err_w[j])
      );
   end

   assign in_ready = (state_q == RUN) && (!out_valid_q || bus.out_ready);
   assign in_fire  = bus.in_valid && in_ready;
   assign out_fire = out_valid_q && bus.out_ready;

   always_comb begin
      state_d     = state_q;
      mode_d      = mode_q;
      in_cnt_d    = in_cnt_q;
      addr_d      = addr_q;
      out_valid_d = out_valid_q;
      s1_d        = s1_q;
      s2_d        = s2_q;
      err_d       = err_q;

      if (out_fire) begin
         out_valid_d = 1'b0;
         if (addr_q != LAST) addr_d = addr_q + 1'b1;
      end
      if (in_fire) begin
         out_valid_d = 1'b1;
         s1_d        = s1_w;
         s2_d        = s2_w;
         in_cnt_d    = in_cnt_q + 1'b1;
         if (|err_w) err_d = 1'b1;
      end

      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d     = RUN;
               mode_d      = mode;
               in_cnt_d    = '0;
               addr_d      = '0;
               out_valid_d = 1'b0;
               err_d       = 1'b0;
            end
         end
         RUN: begin
            if (in_fire && in_cnt_q == LAST) state_d = DRAIN;
         end
         DRAIN: begin
            // Only the final word can still be pending here.
            if (!out_valid_q || out_fire) state_d = FIN;
         end
         FIN: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         mode_q      <= 1'b0;
         in_cnt_q    <= '0;
         addr_q      <= '0;
         out_valid_q <= 1'b0;
         s1_q        <= '0;
         s2_q        <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         mode_q      <= mode_d;
         in_cnt_q    <= in_cnt_d;
         addr_q      <= addr_d;
         out_valid_q <= out_valid_d;
         s1_q        <= s1_d;
         s2_q        <= s2_d;
         err_q       <= err_d;
      end
   end

`ifdef POLYVEC_UNPACK_MASK_EN
   assign bus.PRNG_enable = in_fire && mode_q;
`else
   assign bus.PRNG_enable = 1'b0;
`endif

   assign bus.in_ready    = in_ready;
   assign bus.out_valid   = out_valid_q;
   assign bus.out_addr    = addr_q;
   assign bus.out_data_s1 = s1_q;
   assign bus.out_data_s2 = s2_q;
   assign busy            = (state_q != IDLE);
   assign done            = (state_q == FIN);
   assign coeff_err       = err_q;

endmodule
